mix_column_sequencer: RTL and testbench

- Sequences the AES column register file and the MixColumns unit for one 16-byte state.
- Accepts state bytes serially (column-major) over a valid/ready handshake and writes each column's 4 bytes into the column register file.
- After each column it pulses the MixColumns unit, waits its fixed latency, then captures the 32-bit result and emits it byte-serially downstream.
- Sits between the byte-serial state path and the column register file / MixColumns pair.

---
 rtl/aes_ctrl_pkg.sv | 18 +
 rtl/mc_lat_timer.sv | 28 ++
 rtl/mix_column_sequencer.sv | 146 ++++++++++++++
 tb/tb_mix_column_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and limits for the AES column sequencer.
// Holds the FSM state encoding, column geometry and MC_LAT bounds.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam int COL_BYTES  = 4;
  localparam int NUM_COLS   = 4;
  localparam int MC_LAT_MIN = 1;
  localparam int MC_LAT_MAX = 15;
  localparam int LAT_W      = 4;

endpackage

// File: rtl/mc_lat_timer.sv
// Loadable down-counter timing the MixColumns latency.
// Ports: clk, rst (sync, active-low), load_i, done_o.
module mc_lat_timer
  import aes_ctrl_pkg::*;
#(
  parameter int MC_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic done_o
);

  logic [LAT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LAT_W'(MC_LAT);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - LAT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mix_column_sequencer.sv
// Sequences column loads, MixColumns start/capture and byte drain.
// Ports: byte in (valid/ready), col RF write, mc_start/result, byte out.
module mix_column_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int MC_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  col_wr_data,
  output logic [1:0]  col_wr_index,
  output logic        col_wr_en,
  output logic        mc_start,
  input  logic [31:0] mc_result,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  col_idx,
  output logic        block_done,
  output logic        busy
);

  if (MC_LAT < MC_LAT_MIN || MC_LAT > MC_LAT_MAX) begin : g_bad_lat
    $error("MC_LAT out of range");
  end

  localparam logic [1:0] LAST_B = 2'(COL_BYTES - 1);
  localparam logic [1:0] LAST_C = 2'(NUM_COLS - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  col_q, col_d;
  logic [31:0] hold_q, hold_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        accept;
  logic        lat_load;
  logic        lat_done;
  logic [7:0]  hold_byte;

  assign in_ready = rst &
    ((state_q == IDLE) | (state_q == LOAD));
  assign accept   = in_valid & in_ready;

  assign col_wr_en    = accept;
  assign col_wr_index = byte_q;
  assign col_wr_data  = in_data;

  // Timer arms on the edge that enters COMPUTE.
  assign lat_load = accept & (byte_q == LAST_B);

  mc_lat_timer #(
    .MC_LAT (MC_LAT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (lat_load),
    .done_o (lat_done)
  );

  always_comb begin
    hold_byte = hold_q[31:24];
    unique case (byte_q)
      2'd0: hold_byte = hold_q[31:24];
      2'd1: hold_byte = hold_q[23:16];
      2'd2: hold_byte = hold_q[15:8];
      2'd3: hold_byte = hold_q[7:0];
    endcase
  end

  assign out_valid  = (state_q == DRAIN);
  assign out_data   = out_valid ? hold_byte : 8'h00;
  assign mc_start   = start_q;
  assign block_done = done_q;
  assign col_idx    = col_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    col_d   = col_q;
    hold_d  = hold_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (byte_q == LAST_B) begin
            byte_d  = 2'd0;
            state_d = COMPUTE;
            start_d = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = LOAD;
          end
        end
      end
      COMPUTE: begin
        if (lat_done) begin
          hold_d  = mc_result;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (byte_q == LAST_B) begin
            byte_d = 2'd0;
            if (col_q == LAST_C) begin
              col_d   = 2'd0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              col_d   = col_q + 2'd1;
              state_d = LOAD;
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      byte_q  <= 2'd0;
      col_q   <= 2'd0;
      hold_q  <= 32'h0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      col_q   <= col_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mix_column_sequencer.sv
// Randomised bench for mix_column_sequencer with a MixColumns model.
// Two instances (MC_LAT=1 and 3) share stimulus through a selector.
module tb_mix_column_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] mc_result;
  logic        sel;
  int          lat;

  always #5 clk = ~clk;

  logic       iv_a, iv_b, or_a, or_b;
  logic       ir_a, we_a, ms_a, ov_a, bd_a, by_a;
  logic       ir_b, we_b, ms_b, ov_b, bd_b, by_b;
  logic [7:0] wd_a, od_a, wd_b, od_b;
  logic [1:0] wi_a, ci_a, wi_b, ci_b;

  assign iv_a = in_valid & ~sel;
  assign iv_b = in_valid & sel;
  assign or_a = sel ? 1'b1 : out_ready;
  assign or_b = sel ? out_ready : 1'b1;
  assign lat  = sel ? 3 : 1;

  mix_column_sequencer #(.MC_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(iv_a), .in_ready(ir_a),
    .col_wr_data(wd_a), .col_wr_index(wi_a),
    .col_wr_en(we_a), .mc_start(ms_a),
    .mc_result(mc_result), .out_data(od_a),
    .out_valid(ov_a), .out_ready(or_a),
    .col_idx(ci_a), .block_done(bd_a), .busy(by_a)
  );

  mix_column_sequencer #(.MC_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_valid(iv_b), .in_ready(ir_b),
    .col_wr_data(wd_b), .col_wr_index(wi_b),
    .col_wr_en(we_b), .mc_start(ms_b),
    .mc_result(mc_result), .out_data(od_b),
    .out_valid(ov_b), .out_ready(or_b),
    .col_idx(ci_b), .block_done(bd_b), .busy(by_b)
  );

  logic       o_ir, o_we, o_ms, o_ov, o_bd, o_by;
  logic [7:0] o_wd, o_od;
  logic [1:0] o_wi, o_ci;

  assign o_ir = sel ? ir_b : ir_a;
  assign o_we = sel ? we_b : we_a;
  assign o_ms = sel ? ms_b : ms_a;
  assign o_ov = sel ? ov_b : ov_a;
  assign o_bd = sel ? bd_b : bd_a;
  assign o_by = sel ? by_b : by_a;
  assign o_wd = sel ? wd_b : wd_a;
  assign o_od = sel ? od_b : od_a;
  assign o_wi = sel ? wi_b : wi_a;
  assign o_ci = sel ? ci_b : ci_a;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] byt(input logic [31:0] w,
                                     input int i);
    return w[31-8*i -: 8];
  endfunction

  // AES MixColumns on one column, row 0 in the top byte.
  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3, r0, r1, r2, r3;
    b0 = c[31:24]; b1 = c[23:16];
    b2 = c[15:8];  b3 = c[7:0];
    r0 = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
    r1 = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
    r2 = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
    r3 = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
    return {r0, r1, r2, r3};
  endfunction

  // Bench-side models and bookkeeping.
  logic [7:0]  rf [4];
  logic [31:0] exp_col [4];
  logic [7:0]  got_q [$];
  int  age, n_start, n_done, fbase, d0, s0;
  logic pv, pr, pov;
  logic [7:0] pd;
  bit  rmode;

  // Column RF + MixColumns unit model, plus drain monitor.
  task automatic mon_step();
    if (!rst) begin
      age = -1; pv = 1'b0; pov = 1'b0;
    end else begin
      if (o_ms) begin
        age = 0; n_start++;
      end else if (age >= 0 && age < 1000) begin
        age++;
      end
      if (o_ov && !pov) chk("ov_latency", age, lat + 1);
      if (pv && !pr) begin
        chk("hold_valid", o_ov, 1);
        chk("hold_data", o_od, pd);
      end
      if (o_ov && out_ready) begin
        chk("drain_col", o_ci, (got_q.size() - fbase) / 4);
        got_q.push_back(o_od);
      end
      if (o_bd) begin
        n_done++;
        chk("done_after", got_q.size() - fbase, 16);
      end
      if (o_we) rf[o_wi] = o_wd;
      pov = o_ov; pv = o_ov; pr = out_ready; pd = o_od;
    end
    if (age == lat) mc_result = mix({rf[0], rf[1], rf[2], rf[3]});
    else mc_result = $urandom();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int row, input int col);
    bit acc;
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = o_ir;
      if (acc) begin
        chk("wr_en", o_we, 1);
        chk("wr_idx", o_wi, row);
        chk("wr_data", o_wd, b);
        chk("col_idx", o_ci, col);
      end else begin
        chk("no_wr", o_we, 0);
      end
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 400);
    chk("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    @(negedge clk);
    chk("gap_no_wr", o_we, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_col(input int c, input logic [31:0] w,
                          input bit gaps);
    for (int r = 0; r < 4; r++) begin
      send_byte(byt(w, r), r, c);
      if (gaps) gap();
    end
    exp_col[c] = mix(w);
  endtask

  task automatic start_frame();
    fbase = got_q.size();
    d0 = n_done;
    s0 = n_start;
  endtask

  task automatic finish_frame();
    int t;
    logic [7:0] g;
    t = 0;
    while (n_done == d0 && t < 3000) begin
      tick(); t++;
    end
    repeat (2) tick();
    chk("done_count", n_done - d0, 1);
    chk("start_count", n_start - s0, 4);
    @(negedge clk);
    chk("busy_end", o_by, 0);
    chk("col_end", o_ci, 0);
    chk("ready_end", o_ir, 1);
    @(posedge clk); #1;
    chk("out_count", got_q.size() - fbase, 16);
    for (int k = 0; k < 16; k++) begin
      g = (fbase + k < got_q.size()) ? got_q[fbase + k] : 8'hxx;
      chk($sformatf("out_byte%0d", k), g,
          byt(exp_col[k / 4], k % 4));
    end
  endtask

  task automatic rand_frame(input bit gaps);
    start_frame();
    for (int c = 0; c < 4; c++) send_col(c, $urandom(), gaps);
    finish_frame();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b1; sel = 1'b0; rmode = 1'b0;
    mc_result = 32'h0; age = -1; n_start = 0; n_done = 0;
    fbase = 0; d0 = 0; s0 = 0;
    pv = 1'b0; pr = 1'b0; pov = 1'b0; pd = 8'h00;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    fork
      forever begin @(negedge clk); mon_step(); end
      forever begin
        @(posedge clk); #1;
        if (rmode) out_ready = 1'($urandom_range(0, 1));
      end
      begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
      end
    join_none

    // Reset and idle.
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", o_ir, 1);
    chk("rst_busy", o_by, 0);
    chk("rst_out_valid", o_ov, 0);
    chk("rst_mc_start", o_ms, 0);
    chk("rst_col_idx", o_ci, 0);
    chk("rst_block_done", o_bd, 0);
    chk("rst_out_data", o_od, 0);
    @(posedge clk); #1;

    // Known column, start pulse and backpressure, MC_LAT=1.
    start_frame();
    out_ready = 1'b0;
    send_col(0, 32'hD4BF5D30, 1'b0);
    @(negedge clk);
    chk("mc_start_hi", o_ms, 1);
    chk("busy_compute", o_by, 1);
    chk("ready_compute", o_ir, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mc_start_lo", o_ms, 0);
    for (int t = 0; t < 20 && !o_ov; t++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("first_byte", o_od, 8'h04);
    @(posedge clk); #1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA5;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("bp_data", o_od, 8'h66);
      chk("bp_valid", o_ov, 1);
      chk("bp_in_ready", o_ir, 0);
      chk("bp_no_wr", o_we, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 1; c < 4; c++) send_col(c, $urandom(), 1'b0);
    finish_frame();

    // Full random frames, MC_LAT=1.
    rand_frame(1'b0);
    rmode = 1'b1;
    rand_frame(1'b1);

    // Input gaps and MC_LAT=3.
    rmode = 1'b0;
    out_ready = 1'b1;
    tick();
    sel = 1'b1;
    tick();
    rand_frame(1'b1);
    rmode = 1'b1;
    rand_frame(1'b0);
    rand_frame(1'b1);

    // Mid-operation reset after 2 bytes of column 1.
    rmode = 1'b0;
    out_ready = 1'b1;
    tick();
    sel = 1'b0;
    tick();
    start_frame();
    send_col(0, $urandom(), 1'b0);
    send_byte(8'h11, 0, 1);
    send_byte(8'h22, 1, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_busy", o_by, 0);
    chk("mr_col_idx", o_ci, 0);
    chk("mr_mc_start", o_ms, 0);
    chk("mr_out_valid", o_ov, 0);
    chk("mr_in_ready", o_ir, 1);
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("mr_no_start", o_ms, 0);
      @(posedge clk); #1;
    end
    rand_frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
